sha256_header_feeder: RTL

Sequencer between the miner control logic and `sha256_core`. It captures an 80-byte block header and splits it into two SHA-256 message blocks, adding the standard padding for a 640-bit message. It drives the core's init/next/ready handshake for each block and returns the final digest with a one-cycle done pulse. With `DOUBLE_SHA_EN` it also runs the second SHA-256 pass over the first digest.

---
 rtl/sha256_header_feeder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sha256_header_feeder.sv
// Feeds an 80-byte block header to sha256_core as two padded 512-bit blocks and returns the digest.
// Define DOUBLE_SHA_EN to add a third block that hashes the first digest again (SHA256d).
module sha256_header_feeder #(
   parameter logic MODE = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [639:0] header,
   output logic         busy,
   output logic         done,
   output logic [255:0] digest,
   output logic         core_init,
   output logic         core_next,
   output logic         core_mode,
   output logic [511:0] core_block,
   input  logic         core_ready,
   input  logic [255:0] core_digest
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISS1,
      S_WAIT1,
      S_ISS2,
      S_WAIT2,
`ifdef DOUBLE_SHA_EN
      S_ISS3,
      S_WAIT3,
`endif
      S_FIN
   } state_t;

   state_t         state_q;
   logic [127:0]   hdr_lo_q;
   logic           seen_low_q;
   logic           busy_q;
   logic           done_q;
   logic [255:0]   digest_q;
   logic           init_q;
   logic           next_q;
   logic [511:0]   block_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         hdr_lo_q   <= '0;
         seen_low_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         digest_q   <= '0;
         init_q     <= 1'b0;
         next_q     <= 1'b0;
         block_q    <= '0;
      end else begin
         done_q <= 1'b0;
         init_q <= 1'b0;
         next_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && core_ready) begin
                  hdr_lo_q <= header[127:0];
                  block_q  <= header[639:128];
                  init_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= S_ISS1;
               end
            end
            S_ISS1: begin
               seen_low_q <= 1'b0;
               state_q    <= S_WAIT1;
            end
            // Completion only counts once the core has visibly dropped ready for this block.
            S_WAIT1: begin
               if (!core_ready) begin
                  seen_low_q <= 1'b1;
               end else if (seen_low_q) begin
                  block_q <= {hdr_lo_q, 8'h80, 312'h0, 64'h280};
                  next_q  <= 1'b1;
                  state_q <= S_ISS2;
               end
            end
            S_ISS2: begin
               seen_low_q <= 1'b0;
               state_q    <= S_WAIT2;
            end
            S_WAIT2: begin
               if (!core_ready) begin
                  seen_low_q <= 1'b1;
               end else if (seen_low_q) begin
`ifdef DOUBLE_SHA_EN
                  // Second pass is a fresh hash over the 256-bit first digest.
                  block_q <= {core_digest, 8'h80, 184'h0, 64'h100};
                  init_q  <= 1'b1;
                  state_q <= S_ISS3;
`else
                  digest_q <= core_digest;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_FIN;
`endif
               end
            end
`ifdef DOUBLE_SHA_EN
            S_ISS3: begin
               seen_low_q <= 1'b0;
               state_q    <= S_WAIT3;
            end
            S_WAIT3: begin
               if (!core_ready) begin
                  seen_low_q <= 1'b1;
               end else if (seen_low_q) begin
                  digest_q <= core_digest;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_FIN;
               end
            end
`endif
            S_FIN: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign digest     = digest_q;
   assign core_init  = init_q;
   assign core_next  = next_q;
   assign core_mode  = MODE;
   assign core_block = block_q;

endmodule
